fsk_tx_sequencer: RTL and testbench
===================================

# fsk_tx_sequencer

Wishbone-programmable transmit sequencer for the `mbsFSK` tone generator in the user project area. Software pushes bytes into a small FIFO. The block frames each byte UART-style (start bit, 8 data bits LSB first, stop bit) and emits one symbol per baud period on `fsk_bit_o`. That output selects mark (1) or space (0) tone in the FSK generator; `fsk_en_o` gates tone output.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000, Wishbone base; block decodes `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- `FIFO_DEPTH`, 4, TX byte FIFO entries (power of two, ≥2).
- `DIV_RESET`, 16'd99, reset value of baud divisor.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone classic strobe/cycle/write.
- `wbs_sel_i` in 4: byte selects. Honoured on `DIV` only; other registers ignore it.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data, 0 when not acking.
- `fsk_bit_o` out 1: current symbol (1 = mark).
- `fsk_en_o` out 1: high while a frame is on air.
- `irq_o` out 1: level interrupt, equals `STATUS.done & CTRL.irq_en`.

## Operation
- Registers at word offsets:
  - 0x0 `CTRL`: [0] enable, [1] flush (write-1, self-clearing, reads 0), [2] irq_en.
  - 0x4 `DIV`: [15:0] cycles per symbol minus 1.
  - 0x8 `DATA`: write pushes [7:0]; reads 0.
  - 0xC `STATUS`: [0] busy, [1] full, [2] empty, [3] overflow (sticky, W1C), [4] done (sticky, W1C), [10:8] FIFO count.
- Writes to `DATA` while full are dropped and set overflow.
- Flush empties the FIFO. The frame in progress is not affected.
- FSM states:
  - IDLE: `fsk_en_o`=0, `fsk_bit_o`=1. If enable and FIFO not empty, pop a byte, latch `DIV` into the baud counter, and go to START.
  - START: bit 0.
  - DATA: 8 bits, LSB first.
  - STOP: bit 1.
- Each state bit lasts `DIV+1` cycles, so a frame is 10·(DIV+1) cycles. `DIV` is sampled only at frame start; mid-frame writes apply to the next frame.
- End of STOP: if enable and FIFO not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE and set done.
- Clearing enable mid-frame does not abort: the current frame completes, then the FSM goes to IDLE.
- Push and pop in the same cycle: count unchanged. A push to a full FIFO is dropped even if a pop happens in the same cycle.
- busy = state ≠ IDLE.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `fsk_bit_o`=1, `fsk_en_o`=0, `irq_o`=0.
  - FIFO empty, CTRL=0, `DIV`=`DIV_RESET`, STATUS sticky bits 0, FSM in IDLE.
- Reset mid-frame returns to this state on the next edge.
- Wishbone:
  - `wbs_ack_o` is registered and asserts the cycle after `stb&cyc&addr-hit&!ack`, for exactly one cycle.
  - The register write and FIFO push take effect on the same edge that raises ack.
  - Read data is valid with ack.
  - Off-address accesses are never acked.
- Latency: the FIFO push lands on edge W. If idle and enabled, the pop happens and START drives `fsk_en_o`=1, `fsk_bit_o`=0 from edge W+1.
- Back-to-back frames: the first START cycle of the next frame immediately follows the last STOP cycle.
- done sets on the edge that enters IDLE. A W1C write in the same cycle loses to the set.

## Structure
- Package `fsk_seq_pkg` holds:
  - register offset localparams;
  - the CTRL/STATUS bit indices;
  - a state enum `{IDLE, START, DATA, STOP}`.
- Sub-module `fsk_byte_fifo`: synchronous FIFO (8-bit, `FIFO_DEPTH`) with push, pop, flush, full, empty, count.
- Top holds the Wishbone register file, the baud counter, a 3-bit bit index, the shift register and the FSM.

## Test plan
- Reset mid-frame: assert `wb_rst_i` for 1 cycle during DATA → next cycle `fsk_en_o`=0, `fsk_bit_o`=1, STATUS=0x004, `DIV` reads 99.
- Single byte: DIV=3, enable, write `DATA`=0xA5 → from edge W+1, `fsk_bit_o` = 0,1,0,1,0,0,1,0,1,1 with each symbol held 4 cycles (40 cycles total). Then IDLE, done=1, `irq_o`=1 if irq_en is set.
- Back-to-back: DIV=0, queue 0x00 then 0xFF → 20 contiguous cycles of `fsk_en_o`=1, pattern 0000000001 then 0111111111, no gap.
- Overflow: enable=0, write 5 bytes with depth 4 → count=4, full=1, overflow=1. Write STATUS=0x8 → overflow=0.
- Mid-frame changes: during frame 1, write DIV=7, clear enable, then flush → frame 1 completes at the old rate, the FIFO empties, and no frame 2 is sent.
- Bus: read STATUS at BASE+0xC → ack exactly one cycle after the strobe. An access at BASE+0x10 is never acked.

Source files
------------

// File: rtl/fsk_seq_pkg.sv
// Shared register map, bit positions and FSM state type for the FSK transmit sequencer.
package fsk_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_DONE    = 4;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/fsk_byte_fifo.sv
// Small synchronous byte FIFO; a push while full is dropped, flush clears all entries.
module fsk_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fsk_tx_sequencer.sv
// Wishbone-programmed UART-style framer driving the mark/space select of the FSK tone generator.
module fsk_tx_sequencer
  import fsk_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd99
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        fsk_bit_o,
  output logic        fsk_en_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic          acc;
  logic          wr;
  logic [1:0]    woff;
  logic          wr_ctrl;
  logic          wr_div;
  logic          wr_data;
  logic          wr_status;
  logic          enable;
  logic          irq_en;
  logic          overflow;
  logic          done;
  logic [15:0]   div;
  logic [31:0]   status_word;
  logic [31:0]   rdata;

  logic          fifo_pop;
  logic          fifo_flush;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_nxt;
  logic [15:0]   div_lat;
  logic [15:0]   div_lat_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic [7:0]    shreg;
  logic [7:0]    sh_nxt;
  logic          load;
  logic          done_set;
  logic          sym_end;
  logic          busy;

  logic          unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:16]};

  assign hit       = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc       = hit && !wbs_ack_o;
  assign wr        = acc && wbs_we_i;
  assign woff      = wbs_adr_i[3:2];
  assign wr_ctrl   = wr && (woff == REG_CTRL);
  assign wr_div    = wr && (woff == REG_DIV);
  assign wr_data   = wr && (woff == REG_DATA);
  assign wr_status = wr && (woff == REG_STATUS);
  assign fifo_flush = wr_ctrl && wbs_dat_i[CTRL_FLUSH];

  fsk_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (wr_data),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wbs_dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy = (state != IDLE);

  always_comb begin
    status_word = '0;
    status_word[STAT_BUSY]  = busy;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_OVF]   = overflow;
    status_word[STAT_DONE]  = done;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB] = 3'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    case (woff)
      REG_CTRL:   begin
        rdata[CTRL_EN]     = enable;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      REG_DIV:    rdata[15:0] = div;
      REG_STATUS: rdata = status_word;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rdata : '0;
    end
  end

  // Sticky status: a hardware set in the same cycle as a W1C wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      div      <= DIV_RESET;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= wbs_dat_i[CTRL_EN];
        irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (wr_div && wbs_sel_i[0]) div[7:0]  <= wbs_dat_i[7:0];
      if (wr_div && wbs_sel_i[1]) div[15:8] <= wbs_dat_i[15:8];
      if (wr_data && fifo_full)
        overflow <= 1'b1;
      else if (wr_status && wbs_dat_i[STAT_OVF])
        overflow <= 1'b0;
      if (done_set)
        done <= 1'b1;
      else if (wr_status && wbs_dat_i[STAT_DONE])
        done <= 1'b0;
    end
  end

  assign sym_end = (baud_cnt == '0);

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_cnt;
    bit_nxt     = bit_idx;
    sh_nxt      = shreg;
    div_lat_nxt = div_lat;
    fifo_pop    = 1'b0;
    done_set    = 1'b0;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !fifo_empty) load = 1'b1;
      end
      START: begin
        if (sym_end) begin
          state_nxt = DATA;
          baud_nxt  = div_lat;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (sym_end) begin
          baud_nxt = div_lat;
          sh_nxt   = shreg >> 1;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 1'b1;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (sym_end) begin
          if (enable && !fifo_empty) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_set  = 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
    endcase
    // DIV is captured only here, so mid-frame writes wait for the next frame.
    if (load) begin
      fifo_pop    = 1'b1;
      state_nxt   = START;
      baud_nxt    = div;
      div_lat_nxt = div;
      sh_nxt      = fifo_dout;
      bit_nxt     = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    shreg   <= sh_nxt;
    div_lat <= div_lat_nxt;
  end

  assign fsk_en_o  = busy;
  assign fsk_bit_o = (state == DATA) ? shreg[0] : (state != START);
  assign irq_o     = done && irq_en;

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Directed bench for fsk_tx_sequencer with a frame-level reference model checked every cycle.
module tb_fsk_tx_sequencer;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic        fbit;
  logic        fen;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  fsk_tx_sequencer #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (16'd99)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .fsk_bit_o (fbit),
    .fsk_en_o  (fen),
    .irq_o     (irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes queue plus a frame described by its 10 symbols and elapsed cycles.
  logic [7:0]  mq[$];
  logic        m_en, m_irq_en, m_ovf, m_done, m_active, m_ack;
  logic [15:0] m_div;
  logic [31:0] m_dat;
  logic [9:0]  m_frame;
  int          m_sym, m_elapsed;
  logic        m_acc, m_start, m_idle, m_full_pre;
  logic [31:0] m_rdv;
  logic [7:0]  m_b;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_done = 0; m_active = 0;
      m_ack = 0; m_dat = 0; m_div = 16'd99; m_sym = 1; m_elapsed = 0; m_frame = '1;
    end else begin
      m_acc = stb && cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
      case (adr[3:2])
        2'd0:    m_rdv = {29'd0, m_irq_en, 1'b0, m_en};
        2'd1:    m_rdv = {16'd0, m_div};
        2'd2:    m_rdv = 32'd0;
        default: m_rdv = {21'd0, 3'(mq.size()), 3'd0, m_done, m_ovf,
                          (mq.size() == 0), (mq.size() == DEPTH), m_active};
      endcase
      m_dat = (m_acc && !we) ? m_rdv : 32'd0;
      m_ack = m_acc;
      m_start = 0; m_idle = 0;
      if (m_active) begin
        m_elapsed++;
        if (m_elapsed == 10 * m_sym) begin
          if (m_en && mq.size() > 0) m_start = 1;
          else begin m_active = 0; m_idle = 1; end
        end
      end else if (m_en && mq.size() > 0) begin
        m_start = 1;
      end
      m_full_pre = (mq.size() == DEPTH);
      if (m_start) begin
        m_b = mq.pop_front();
        m_frame = {1'b1, m_b, 1'b0};
        m_sym = int'(m_div) + 1;
        m_elapsed = 0;
        m_active = 1;
      end
      if (m_acc && we) begin
        case (adr[3:2])
          2'd0: begin
            m_en = dat_w[0]; m_irq_en = dat_w[2];
            if (dat_w[1]) mq.delete();
          end
          2'd1: begin
            if (sel[0]) m_div[7:0]  = dat_w[7:0];
            if (sel[1]) m_div[15:8] = dat_w[15:8];
          end
          2'd2: if (m_full_pre) m_ovf = 1; else mq.push_back(dat_w[7:0]);
          default: begin
            if (dat_w[3]) m_ovf = 0;
            if (dat_w[4]) m_done = 0;
          end
        endcase
      end
      if (m_idle) m_done = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ack", {31'd0, ack}, {31'd0, m_ack});
      check("dat_o", dat_r, m_dat);
      check("fsk_en", {31'd0, fen}, {31'd0, m_active});
      check("fsk_bit", {31'd0, fbit}, {31'd0, m_active ? m_frame[m_elapsed / m_sym] : 1'b1});
      check("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
    end
  end

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] rd);
    @(negedge clk);
    adr = a; we = w; dat_w = d; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(negedge clk);
    check("bus_ack_next_cycle", {31'd0, ack}, 32'd1);
    rd = dat_r;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(BASE + {28'd0, off}, 1'b1, d, rd);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(BASE + {28'd0, off}, 1'b0, 32'd0, rd);
    check(nm, rd, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0]  pat_a5;
    logic [19:0] pat_b2b;
    int          k, acks;

    pat_a5  = 10'b11_0100_1010;        // index 0 first: 0,1,0,1,0,0,1,0,1,1
    pat_b2b = 20'b0000000001_0111111111;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_en", {31'd0, fen}, 32'd0);
    check("reset_bit", {31'd0, fbit}, 32'd1);
    rd_chk("reset_status", 4'hC, 32'h004);
    rd_chk("reset_div", 4'h4, 32'd99);
    rd_chk("reset_ctrl", 4'h0, 32'd0);

    // Single byte at DIV=3.
    wr(4'h4, 32'd3);
    wr(4'h0, 32'h5);
    wr(4'h8, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("a5_en", {31'd0, fen}, 32'd1);
      check("a5_bit", {31'd0, fbit}, {31'd0, pat_a5[i / 4]});
    end
    rd_chk("a5_status_done", 4'hC, 32'h014);
    check("a5_irq", {31'd0, irq}, 32'd1);
    wr(4'hC, 32'h10);
    rd_chk("done_cleared", 4'hC, 32'h004);

    // Back-to-back frames at DIV=0.
    wr(4'h0, 32'h0);
    wr(4'h4, 32'd0);
    wr(4'h8, 32'h00);
    wr(4'h8, 32'hFF);
    wr(4'h0, 32'h1);
    k = 0;
    while (fen !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("b2b_start_latency", k, 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      check("b2b_en", {31'd0, fen}, 32'd1);
      check("b2b_bit", {31'd0, fbit}, {31'd0, pat_b2b[19 - i]});
    end
    @(negedge clk);
    check("b2b_end_en", {31'd0, fen}, 32'd0);

    // Overflow with enable off.
    wr(4'h0, 32'h0);
    wr(4'hC, 32'h10);
    for (int i = 0; i < 5; i++) wr(4'h8, 32'h10 + i);
    rd_chk("ovf_status", 4'hC, 32'h40A);
    wr(4'hC, 32'h8);
    rd_chk("ovf_cleared", 4'hC, 32'h402);
    wr(4'h0, 32'h2);
    rd_chk("flush_status", 4'hC, 32'h004);

    // Mid-frame DIV change, disable and flush.
    wr(4'h4, 32'd1);
    wr(4'h0, 32'h1);
    wr(4'h8, 32'h3C);
    wr(4'h8, 32'h81);
    wr(4'h4, 32'd7);
    wr(4'h0, 32'h0);
    wr(4'h0, 32'h2);
    check("mid_still_busy", {31'd0, fen}, 32'd1);
    repeat (30) @(negedge clk);
    rd_chk("mid_status", 4'hC, 32'h014);
    rd_chk("mid_div", 4'h4, 32'd7);

    // Off-address access never acked.
    @(negedge clk);
    adr = BASE + 32'h10; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("offaddr_acks", acks, 32'd0);

    // Reset during DATA.
    wr(4'hC, 32'h10);
    wr(4'h4, 32'd3);
    wr(4'h0, 32'h1);
    wr(4'h8, 32'h5A);
    repeat (10) @(negedge clk);
    check("pre_rst_en", {31'd0, fen}, 32'd1);
    check("pre_rst_bit", {31'd0, fbit}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_en", {31'd0, fen}, 32'd0);
    check("rst_mid_bit", {31'd0, fbit}, 32'd1);
    rd_chk("rst_mid_status", 4'hC, 32'h004);
    rd_chk("rst_mid_div", 4'h4, 32'd99);
    repeat (5) @(negedge clk);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
